// File: rtl/and_or_pkg.sv
// Shared types and constants for the and_or sweep sequencer.
// State encoding and the reference truth table of Y = (A & B) | C.
package and_or_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    FINISH = 2'd3
  } state_e;

  localparam int         NUM_VECTORS = 8;
  localparam logic [7:0] AND_OR_EXP  = 8'hEA;

endpackage

// File: rtl/and_or_sweep_ctrl_if.sv
// Control/result bus between the sweep sequencer, the board side
// and the and_or datapath it drives.
interface and_or_sweep_ctrl_if;
  import and_or_pkg::*;

  logic       START;
  logic       Y;
  logic       A;
  logic       B;
  logic       C;
  logic       BUSY;
  logic       DONE;
  logic       PASS;
  logic [3:0] ERR_CNT;
  logic [7:0] FAIL_MASK;

  modport master (
    input  START, Y,
    output A, B, C, BUSY, DONE,
    output PASS, ERR_CNT, FAIL_MASK
  );

  modport slave (
    output START, Y,
    input  A, B, C, BUSY, DONE,
    input  PASS, ERR_CNT, FAIL_MASK
  );

endinterface

// File: rtl/and_or_sweep_ctrl.sv
// Sweeps all eight {A,B,C} vectors through and_or, samples Y after a
// settle delay and accumulates a fail mask, error count and pass flag.
module and_or_sweep_ctrl
  import and_or_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [7:0]  EXP_MAP       = AND_OR_EXP
) (
  input logic             CLK,
  input logic             RST,
  and_or_sweep_ctrl_if.master bus
);

  localparam logic [3:0] CNT_LAST = 4'(SETTLE_CYCLES - 1);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] cnt_q, cnt_d;
  logic [2:0] abc_q, abc_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       pass_q, pass_d;
  logic [3:0] err_q, err_d;
  logic [7:0] mask_q, mask_d;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      abc_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      pass_q  <= 1'b0;
      err_q   <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      abc_q   <= abc_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      pass_q  <= pass_d;
      err_q   <= err_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pass_d  = pass_q;
    err_d   = err_q;
    mask_d  = mask_q;
    unique case (state_q)
      IDLE: begin
        if (bus.START) begin
          idx_d   = '0;
          cnt_d   = '0;
          mask_d  = '0;
          err_d   = '0;
          pass_d  = 1'b0;
          state_d = SETTLE;
        end
      end
      SETTLE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == CNT_LAST) state_d = SAMPLE;
      end
      SAMPLE: begin
        if (bus.Y != EXP_MAP[idx_q]) begin
          mask_d[idx_q] = 1'b1;
          err_d         = err_q + 4'd1;
        end
        // pass is resolved here so it is valid alongside DONE
        if (idx_q == 3'd7) begin
          state_d = FINISH;
          pass_d  = (err_d == 4'd0);
        end else begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = SETTLE;
        end
      end
      FINISH: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // outputs are registered from the next state so they align with it
  always_comb begin
    busy_d = (state_d == SETTLE) || (state_d == SAMPLE);
    abc_d  = busy_d ? idx_d : 3'd0;
    done_d = (state_d == FINISH);
  end

  assign bus.A         = abc_q[2];
  assign bus.B         = abc_q[1];
  assign bus.C         = abc_q[0];
  assign bus.BUSY      = busy_q;
  assign bus.DONE      = done_q;
  assign bus.PASS      = pass_q;
  assign bus.ERR_CNT   = err_q;
  assign bus.FAIL_MASK = mask_q;

endmodule
